// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared waveform mode and configuration types for wave_generator.
package wave_gen_pkg;
    localparam int WG_N    = 8;
    localparam int WG_HP_W = 16;

    typedef enum logic [1:0] {
        TRIANGLE = 2'd0,
        SAW_UP   = 2'd1,
        SAW_DOWN = 2'd2,
        SQUARE   = 2'd3
    } wave_mode_t;

    typedef struct packed {
        wave_mode_t           mode;
        logic [WG_N-1:0]      step;
        logic [WG_N-1:0]      lo;
        logic [WG_N-1:0]      hi;
        logic [WG_HP_W-1:0]   half_period;
    } wave_cfg_t;
endpackage

// File: rtl/wave_generator_if.sv
// wave_generator_if: control/config inputs and sample outputs of the waveform source.
interface wave_generator_if
    import wave_gen_pkg::*;
#(
    parameter int N    = WG_N,
    parameter int HP_W = WG_HP_W
);
    logic            ena;
    logic            cfg_load;
    wave_mode_t      mode;
    logic [N-1:0]    step;
    logic [N-1:0]    lo;
    logic [N-1:0]    hi;
    logic [HP_W-1:0] half_period;
    logic [N-1:0]    out;
    logic            dir_down;
    logic            period_done;

    modport master (
        output ena, cfg_load, mode, step, lo, hi, half_period,
        input  out, dir_down, period_done
    );
    modport slave (
        input  ena, cfg_load, mode, step, lo, hi, half_period,
        output out, dir_down, period_done
    );
endinterface

// File: rtl/adder_n.sv
// adder_n: W-bit add/subtract with a W+1-bit result so carries and borrows stay visible.
module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W:0]   y
);
    assign y = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/wave_step_calc.sv
// wave_step_calc: next sample, direction and period-wrap flag for one waveform step.
module wave_step_calc
    import wave_gen_pkg::*;
#(
    parameter int N = WG_N
) (
    input  wave_cfg_t     cfg,
    input  logic [N-1:0]  out,
    input  logic          dir_down,
    output logic [N-1:0]  next_out,
    output logic          next_dir,
    output logic          wrap
);
    logic [N:0] up, dn, lo_st, out_x, hi_x;
    logic       unused_hp;

    assign unused_hp = ^cfg.half_period;
    assign out_x     = {1'b0, out};
    assign hi_x      = {1'b0, cfg.hi};

    adder_n #(.W(N)) u_up (.a(out),    .b(cfg.step), .sub(1'b0), .y(up));
    adder_n #(.W(N)) u_dn (.a(out),    .b(cfg.step), .sub(1'b1), .y(dn));
    adder_n #(.W(N)) u_lo (.a(cfg.lo), .b(cfg.step), .sub(1'b0), .y(lo_st));

    // A borrow out of out-step means the descent has already passed lo+step.
    always_comb begin
        next_out = cfg.lo;
        next_dir = 1'b0;
        wrap     = 1'b0;
        if (cfg.lo < cfg.hi) begin
            if (cfg.mode == TRIANGLE && !dir_down) begin
                next_dir = up >= hi_x;
                next_out = next_dir ? cfg.hi : up[N-1:0];
            end else if (cfg.mode == TRIANGLE) begin
                wrap     = dn[N] || out_x <= lo_st;
                next_dir = !wrap;
                next_out = wrap ? cfg.lo : dn[N-1:0];
            end else if (cfg.mode == SAW_UP) begin
                wrap     = up > hi_x;
                next_out = wrap ? cfg.lo : up[N-1:0];
            end else if (cfg.mode == SAW_DOWN) begin
                wrap     = dn[N] || out_x < lo_st;
                next_out = wrap ? cfg.hi : dn[N-1:0];
            end else begin
                wrap     = out == cfg.hi;
                next_out = wrap ? cfg.lo : cfg.hi;
            end
        end
    end
endmodule

// File: rtl/wave_generator.sv
// wave_generator: programmable triangle/sawtooth/square source with per-period pulse.
module wave_generator
    import wave_gen_pkg::*;
#(
    parameter int N    = WG_N,
    parameter int HP_W = WG_HP_W
) (
    input logic             clk,
    input logic             rst_n,
    wave_generator_if.slave bus
);
    wave_cfg_t       cfg;
    logic [N-1:0]    out_q, next_out;
    logic            dir_q, next_dir, wrap, done_q;
    logic [HP_W-1:0] hp_cnt, hp_last;
    logic            hp_hit, adv;

    wave_step_calc #(.N(N)) u_calc (
        .cfg      (cfg),
        .out      (out_q),
        .dir_down (dir_q),
        .next_out (next_out),
        .next_dir (next_dir),
        .wrap     (wrap)
    );

    // A zero half-period behaves as one so the square still toggles every cycle.
    assign hp_last = (cfg.half_period == '0) ? '0 : cfg.half_period - 1'b1;
    assign hp_hit  = hp_cnt == hp_last;
    assign adv     = bus.ena && (cfg.mode != SQUARE || hp_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg    <= '{mode: TRIANGLE, step: WG_N'(1), lo: '0, hi: '1, half_period: WG_HP_W'(1)};
            out_q  <= '0;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
            hp_cnt <= '0;
        end else if (bus.cfg_load) begin
            cfg    <= '{mode: bus.mode, step: bus.step, lo: bus.lo, hi: bus.hi, half_period: bus.half_period};
            out_q  <= (bus.mode == SAW_DOWN && bus.lo < bus.hi) ? bus.hi : bus.lo;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
            hp_cnt <= '0;
        end else begin
            done_q <= adv && wrap;
            if (bus.ena) hp_cnt <= (cfg.mode == SQUARE && !hp_hit) ? hp_cnt + 1'b1 : '0;
            if (adv) begin
                out_q <= next_out;
                dir_q <= next_dir;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.dir_down    = dir_q;
    assign bus.period_done = done_q;
endmodule

// File: tb/tb_wave_generator.sv
// tb_wave_generator: table vectors, directed corner sequences and random traffic vs a behavioural model.
module tb_wave_generator;
    import wave_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    wave_generator_if #(.N(8), .HP_W(16)) bus();
    wave_generator #(.N(8), .HP_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic e, l;
        int   mode, st, lo, hi, hp;
        int   eo, ed, ep;
    } vec_t;

    int m_out, m_dir, m_pd, m_hp;
    int c_mode, c_step, c_lo, c_hi, c_hp;

    task automatic model_reset();
        m_out = 0; m_dir = 0; m_pd = 0; m_hp = 0;
        c_mode = 0; c_step = 1; c_lo = 0; c_hi = 255; c_hp = 1;
    endtask

    task automatic model_edge(input logic e, input logic l, input int mode, input int st,
                              input int lo, input int hi, input int hp);
        int h;
        if (l) begin
            c_mode = mode; c_step = st; c_lo = lo; c_hi = hi; c_hp = hp;
            m_out = (mode == 2 && lo < hi) ? hi : lo;
            m_dir = 0; m_hp = 0; m_pd = 0;
            return;
        end
        m_pd = 0;
        if (!e) return;
        if (c_lo >= c_hi) begin
            m_out = c_lo;
            return;
        end
        case (c_mode)
            0: if (m_dir == 0) begin
                   if (m_out + c_step >= c_hi) begin m_out = c_hi; m_dir = 1; end
                   else m_out += c_step;
               end else begin
                   if (m_out <= c_lo + c_step) begin m_out = c_lo; m_dir = 0; m_pd = 1; end
                   else m_out -= c_step;
               end
            1: if (m_out + c_step > c_hi) begin m_out = c_lo; m_pd = 1; end
               else m_out += c_step;
            2: if (m_out < c_lo + c_step) begin m_out = c_hi; m_pd = 1; end
               else m_out -= c_step;
            default: begin
                h = (c_hp == 0) ? 1 : c_hp;
                m_hp++;
                if (m_hp == h) begin
                    m_hp = 0;
                    if (m_out == c_hi) begin m_out = c_lo; m_pd = 1; end
                    else m_out = c_hi;
                end
            end
        endcase
    endtask

    task automatic chk(input string nm, input int eo, input int ed, input int ep);
        tests++;
        if (bus.out !== 8'(eo) || bus.dir_down !== 1'(ed) || bus.period_done !== 1'(ep)) begin
            fails++;
            $display("FAIL %s: got out=%0d dir_down=%b period_done=%b, want out=%0d dir_down=%0d period_done=%0d",
                     nm, bus.out, bus.dir_down, bus.period_done, eo, ed, ep);
        end
    endtask

    task automatic tick(input logic e, input logic l, input int mode, input int st,
                        input int lo, input int hi, input int hp);
        bus.ena = e; bus.cfg_load = l; bus.mode = wave_mode_t'(mode);
        bus.step = 8'(st); bus.lo = 8'(lo); bus.hi = 8'(hi); bus.half_period = 16'(hp);
        @(posedge clk);
        model_edge(e, l, mode, st, lo, hi, hp);
        @(negedge clk);
    endtask

    task automatic run_model(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
            chk(nm, m_out, m_dir, m_pd);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int a, b, pulses;
        logic e, l;
        bus.ena = 0; bus.cfg_load = 0; bus.mode = TRIANGLE;
        bus.step = 0; bus.lo = 0; bus.hi = 0; bus.half_period = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", 0, 0, 0);
        rst_n = 1'b1;

        pulses = 0;
        for (int i = 0; i < 515; i++) begin
            tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
            chk("default_tri", m_out, m_dir, m_pd);
            pulses += int'(bus.period_done);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL default_tri_pulses: got %0d, want 1", pulses);
        end

        tbl.push_back('{1'b0, 1'b1, 1,  6,  0,  20, 0,  0, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  6, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 12, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 18, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  0, 0, 1});
        tbl.push_back('{1'b0, 1'b0, 0,  0,  0,   0, 0,  0, 0, 0});
        tbl.push_back('{1'b1, 1'b1, 2,  6,  0,  20, 0, 20, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 14, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  8, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  2, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 20, 0, 1});
        tbl.push_back('{1'b1, 1'b1, 0,  7, 10,  50, 0, 10, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 17, 0, 0});
        tbl.push_back('{1'b0, 1'b0, 0,  0,  0,   0, 0, 17, 0, 0});
        tbl.push_back('{1'b0, 1'b0, 0,  0,  0,   0, 0, 17, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 24, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 31, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 38, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 45, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 50, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 43, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 36, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 29, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 22, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 15, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 10, 0, 1});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 17, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 3,  0,  3, 200, 4,  3, 0, 0});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b0, 0, 0, 0, 0, 0,   3, 0, 0});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 1'b0, 0, 0, 0, 0, 0, 200, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  3, 0, 1});
        tbl.push_back('{1'b0, 1'b1, 3,  0,  3, 200, 0,  3, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 200, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  3, 0, 1});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 200, 0, 0});
        tbl.push_back('{1'b1, 1'b1, 0,  5, 40,  40, 0, 40, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 40, 0, 0});
        tbl.push_back('{1'b1, 1'b1, 2,  5, 40,  40, 0, 40, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0, 40, 0, 0});
        tbl.push_back('{1'b1, 1'b1, 1,  0,  5,  60, 0,  5, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 0,  0,  0,   0, 0,  5, 0, 0});
        foreach (tbl[i]) begin
            tick(tbl[i].e, tbl[i].l, tbl[i].mode, tbl[i].st, tbl[i].lo, tbl[i].hi, tbl[i].hp);
            chk($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ed, tbl[i].ep);
        end

        tick(1'b1, 1'b1, 0, 7, 10, 50, 0);
        chk("tri_load", 10, 0, 0);
        run_model("tri_descent", 9);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 0, 0, 0);
        model_reset();
        @(negedge clk);
        chk("reset_hold", 0, 0, 0);
        rst_n = 1'b1;
        run_model("post_reset", 4);
        chk("post_reset_val", 4, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 39) == 0);
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0 && a > b) begin int t = a; a = b; b = t; end
            tick(e, l, $urandom_range(0, 3), $urandom_range(0, 40), a, b, $urandom_range(0, 5));
            chk("random", m_out, m_dir, m_pd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
